// File: rtl/layer_2_engine_if.sv
// Bus bundle for layer_2_engine: request, packed activations, weight ROM port and scores.
// Handshake: start is a one-cycle request taken only while busy=0; done pulses one cycle when layer_2 changes.
interface layer_2_engine_if #(
    parameter int BITS = 32,
    parameter int N_IN = 64
);
    localparam int AW = $clog2(10 * (N_IN + 1));

    logic                     start;
    logic [BITS*N_IN-1:0]     layer_1;
    logic [AW-1:0]            w_addr;
    logic signed [BITS-1:0]   w_data;
    logic                     busy;
    logic                     done;
    logic [BITS*10-1:0]       layer_2;
    logic [1:0]               dbg_state;

    modport master (
        output start, layer_1, w_data,
        input  w_addr, busy, done, layer_2, dbg_state
    );

    modport slave (
        input  start, layer_1, w_data,
        output w_addr, busy, done, layer_2, dbg_state
    );
endinterface

// File: rtl/layer_2_engine.sv
// Output-layer evaluator: 10 neurons, bias + sum of (act*w)>>>FRAC streamed from a weight ROM.
// Define LAYER_2_ENGINE_SAT_EN for saturating products and accumulation; default wraps.
module layer_2_engine #(
    parameter int BITS = 32,
    parameter int N_IN = 64,
    parameter int FRAC = 16
) (
    input  logic               clk,
    input  logic               rst,
    layer_2_engine_if.slave    bus
);
    localparam int AW = $clog2(10 * (N_IN + 1));
    localparam int CW = $clog2(N_IN + 2);
    localparam logic [AW-1:0] STRIDE = AW'(N_IN + 1);

`ifdef LAYER_2_ENGINE_SAT_EN
    localparam logic signed [BITS-1:0]   S_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0]   S_MIN = {1'b1, {(BITS-1){1'b0}}};
    localparam logic signed [2*BITS-1:0] P_MAX = {{(BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [2*BITS-1:0] P_MIN = {{(BITS+1){1'b1}}, {(BITS-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic signed [BITS-1:0] scale_prod(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic signed [2*BITS-1:0] full;
        full = (2*BITS)'(a) * (2*BITS)'(b);
        full = full >>> FRAC;
`ifdef LAYER_2_ENGINE_SAT_EN
        if (full > P_MAX) return S_MAX;
        if (full < P_MIN) return S_MIN;
`endif
        return BITS'(full);
    endfunction

    function automatic logic signed [BITS-1:0] acc_add(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
`ifdef LAYER_2_ENGINE_SAT_EN
        logic signed [BITS:0] s;
        s = (BITS+1)'(a) + (BITS+1)'(b);
        if (s > (BITS+1)'(S_MAX)) return S_MAX;
        if (s < (BITS+1)'(S_MIN)) return S_MIN;
        return BITS'(s);
`else
        return a + b;
`endif
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             n_q, n_d;
    logic [AW-1:0]          base_q, base_d;
    logic [AW-1:0]          w_addr_q, w_addr_d;
    logic signed [BITS-1:0] acc_q, acc_d;
    logic signed [BITS-1:0] act_q [N_IN];
    logic signed [BITS-1:0] act_d [N_IN];
    logic signed [BITS-1:0] slot_q [10];
    logic signed [BITS-1:0] slot_d [10];
    logic [BITS*10-1:0]     layer_2_q, layer_2_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [CW-1:0]          item;
    logic                   absorb;
    logic signed [BITS-1:0] act_sel;

    // ROM data lags the address by one cycle, so the item being absorbed is one behind cnt;
    // item 0 is the bias, item i+1 is weight i, and DRAIN absorbs the last weight.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        base_d    = base_q;
        acc_d     = acc_q;
        act_d     = act_q;
        slot_d    = slot_q;
        layer_2_d = layer_2_q;
        done_d    = 1'b0;

        item   = (state_q == DRAIN) ? CW'(N_IN) : cnt_q - CW'(1);
        absorb = ((state_q == ISSUE) && (cnt_q != '0)) || (state_q == DRAIN);

        act_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (item == CW'(i + 1)) act_sel = act_q[i];
        end

        if (absorb) begin
            if (item == '0) acc_d = bus.w_data;
            else            acc_d = acc_add(acc_q, scale_prod(act_sel, bus.w_data));
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < N_IN; i++) begin
                        act_d[i] = bus.layer_1[BITS*(N_IN-i)-1 -: BITS];
                    end
                    n_d     = '0;
                    base_d  = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == CW'(N_IN)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                for (int s = 0; s < 10; s++) begin
                    if (n_q == 4'(s)) slot_d[s] = acc_d;
                end
                // Scores go out on the same edge that raises done, so layer_2 never shows partial results.
                if (n_q == 4'd9) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    for (int s = 0; s < 10; s++) begin
                        layer_2_d[BITS*(10-s)-1 -: BITS] = slot_d[s];
                    end
                end else begin
                    n_d     = n_q + 4'd1;
                    base_d  = base_q + STRIDE;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d != IDLE);
        w_addr_d = (state_d == ISSUE) ? base_d + AW'(cnt_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            base_q    <= '0;
            w_addr_q  <= '0;
            acc_q     <= '0;
            layer_2_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < N_IN; i++) act_q[i] <= '0;
            for (int s = 0; s < 10; s++) slot_q[s] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            base_q    <= base_d;
            w_addr_q  <= w_addr_d;
            acc_q     <= acc_d;
            layer_2_q <= layer_2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < N_IN; i++) act_q[i] <= act_d[i];
            for (int s = 0; s < 10; s++) slot_q[s] <= slot_d[s];
        end
    end

    assign bus.w_addr    = w_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.layer_2   = layer_2_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_layer_2_engine.sv
// Bench for layer_2_engine (BITS=32, N_IN=4, FRAC=8): table vectors, start/reset corner sequences,
// random vectors against a longint reference model; expected scores flow through exp_q.
module tb_layer_2_engine;
    localparam int BITS  = 32;
    localparam int N_IN  = 4;
    localparam int FRAC  = 8;
    localparam int ROM_N = 10 * (N_IN + 1);
    localparam int LAT   = 10 * (N_IN + 2) + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_2_engine_if #(.BITS(BITS), .N_IN(N_IN)) bus();

    layer_2_engine #(.BITS(BITS), .N_IN(N_IN), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom   [ROM_N];
    logic [31:0] act_v [N_IN];

    always @(posedge clk) begin
        bus.w_data <= (int'(bus.w_addr) < ROM_N) ? rom[bus.w_addr] : 32'hDEADBEEF;
    end

    // scoreboard
    logic [319:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] act;
        logic [31:0] wt;
        logic [31:0] bias_other;
        logic [31:0] bias3;
        logic [31:0] exp_other;
        logic [31:0] exp3;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic longint fit32(input longint v);
`ifdef LAYER_2_ENGINE_SAT_EN
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
`else
        logic [31:0] t;
        t = v[31:0];
        return longint'($signed(t));
`endif
    endfunction

    function automatic logic [31:0] model_score(input int n);
        longint acc;
        longint p;
        acc = longint'($signed(rom[n*(N_IN+1)]));
        for (int i = 0; i < N_IN; i++) begin
            p   = longint'($signed(act_v[i])) * longint'($signed(rom[n*(N_IN+1)+1+i]));
            p   = fit32(p >>> FRAC);
            acc = fit32(acc + p);
        end
        return acc[31:0];
    endfunction

    function automatic logic [319:0] pack_exp(input logic [31:0] other, input logic [31:0] s3);
        logic [319:0] e;
        for (int n = 0; n < 10; n++) e[32*(10-n)-1 -: 32] = (n == 3) ? s3 : other;
        return e;
    endfunction

    // driver tasks
    task automatic load_table(input vec_t v);
        for (int n = 0; n < 10; n++) begin
            rom[n*(N_IN+1)] = (n == 3) ? v.bias3 : v.bias_other;
            for (int i = 0; i < N_IN; i++) rom[n*(N_IN+1)+1+i] = v.wt;
        end
        for (int i = 0; i < N_IN; i++) act_v[i] = v.act;
    endtask

    task automatic drive_layer_1();
        for (int i = 0; i < N_IN; i++) bus.layer_1[32*(N_IN-i)-1 -: 32] = act_v[i];
    endtask

    task automatic run_eval(input bit extra);
        logic [319:0] prev;
        int  done_cyc;
        int  done_cnt;
        bit  stable;
        bit  busy_ok;
        prev     = bus.layer_2;
        stable   = 1'b1;
        busy_ok  = 1'b1;
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk);
        drive_layer_1();
        bus.start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= LAT + 70; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.layer_1 = {4{$urandom}};
            bus.start = extra && (cyc == 20 || cyc == LAT);
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    if (exp_q.size() > 0) check("scores", bus.layer_2, exp_q.pop_front());
                end
            end else if (done_cyc < 0 && bus.layer_2 !== prev) begin
                stable = 1'b0;
            end
            if (done_cyc < 0 && !bus.busy) busy_ok = 1'b0;
            if (!extra && done_cyc >= 0 && cyc == done_cyc + 2) break;
        end
        bus.start = 1'b0;
        if (done_cyc < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        check("done_cycle", 320'(done_cyc), 320'(LAT));
        check("layer_2_stable", 320'(stable), 320'(1));
        check("busy_during", 320'(busy_ok), 320'(1));
        check("busy_after", 320'(bus.busy), 320'(0));
        check("w_addr_idle", 320'(bus.w_addr), 320'(0));
        if (extra) check("single_done", 320'(done_cnt), 320'(1));
    endtask

    task automatic reset_mid_eval();
        exp_q.push_back(pack_exp(32'h0, 32'h0));
        @(negedge clk);
        drive_layer_1();
        bus.start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        check("rst_busy", 320'(bus.busy), 320'(0));
        check("rst_layer_2", bus.layer_2, 320'(0));
        check("rst_w_addr", 320'(bus.w_addr), 320'(0));
        check("rst_done", 320'(bus.done), 320'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h00000100, 32'h00000100, 32'h0, 32'h0, 32'h00000400, 32'h00000400};
        tbl[1] = '{32'hFFFFFF00, 32'h00000100, 32'h0, 32'h00000100, 32'hFFFFFC00, 32'hFFFFFD00};
`ifdef LAYER_2_ENGINE_SAT_EN
        tbl[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h7FFFFFFF};
        tbl[5] = '{32'h00010000, 32'h00400000, 32'h0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
`else
        tbl[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'hFC000000, 32'hFC000000};
        tbl[5] = '{32'h00010000, 32'h00400000, 32'h0, 32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF};
`endif
        tbl[3] = '{32'h00000000, 32'h00012345, 32'h00000055, 32'h80000000, 32'h00000055, 32'h80000000};
        tbl[4] = '{32'h00000180, 32'hFFFFFF00, 32'h00000010, 32'h0, 32'hFFFFFA10, 32'hFFFFFA00};
        tbl[6] = '{32'hFFFFFFFF, 32'h00000080, 32'h0, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFFC};

        for (int i = 0; i < ROM_N; i++) rom[i] = '0;
        bus.start   = 1'b0;
        bus.layer_1 = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_layer_2", bus.layer_2, 320'(0));
        check("reset_busy", 320'(bus.busy), 320'(0));
        check("reset_done", 320'(bus.done), 320'(0));
        check("reset_w_addr", 320'(bus.w_addr), 320'(0));
        check("reset_state", 320'(bus.dbg_state), 320'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            load_table(tbl[v]);
            exp_q.push_back(pack_exp(tbl[v].exp_other, tbl[v].exp3));
            run_eval(v == 1);
        end

        load_table(tbl[0]);
        reset_mid_eval();
        exp_q.push_back(pack_exp(32'h00000400, 32'h00000400));
        run_eval(1'b0);

        for (int r = 0; r < 3; r++) begin
            logic [319:0] e;
            for (int k = 0; k < ROM_N; k++) begin
                rom[k] = (r == 2) ? $urandom : 32'($urandom_range(0, 4095)) - 32'd2048;
            end
            for (int i = 0; i < N_IN; i++) begin
                act_v[i] = (r == 2) ? $urandom : 32'($urandom_range(0, 4095)) - 32'd2048;
            end
            for (int n = 0; n < 10; n++) e[32*(10-n)-1 -: 32] = model_score(n);
            exp_q.push_back(e);
            run_eval(1'b0);
        end

        check("queue_empty", 320'(exp_q.size()), 320'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/layer_2_engine.md
LAYER_2_ENGINE -- requirements
Module: layer_2_engine

Interface
REQ-001 Parameter BITS, default 32; signed fixed-point word width of activations, weights, biases and scores.
REQ-002 Parameter N_IN, default 64; number of hidden (layer-1) activations per neuron.
REQ-003 Parameter FRAC, default 16; fractional bits of the fixed-point format.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port start  input  1  single-cycle request to evaluate the output layer.
REQ-007 Port layer_1  input  BITS*N_IN  packed signed activations; activation i at [BITS*(N_IN-i)-1 -: BITS].
REQ-008 Port w_addr  output  clog2(10*(N_IN+1))  weight/bias ROM read address.
REQ-009 Port w_data  input  BITS  signed ROM data, valid one cycle after w_addr.
REQ-010 Port busy  output  1  high while an evaluation is in progress.
REQ-011 Port done  output  1  one-cycle pulse when layer_2 is updated.
REQ-012 Port layer_2  output  BITS*10  packed signed scores; neuron n (0..9) at [BITS*(10-n)-1 -: BITS], digit 9 at LSBs.

Function
REQ-013 ROM map: neuron n bias at n*(N_IN+1); weight i at n*(N_IN+1)+1+i.
REQ-014 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: when start=1, capture layer_1 into an internal register, clear n and the accumulator, and enter ISSUE; layer_1 is not used again after capture.
REQ-016 ISSUE: drive N_IN+1 consecutive addresses for neuron n (bias first), one per cycle, then enter DRAIN.
REQ-017 Accumulation: the returned bias loads acc; each returned weight adds (act_i*w_i)>>>FRAC to acc.
REQ-018 Product width: the product is 2*BITS wide; after the arithmetic shift it is truncated to BITS.
REQ-019 Overflow: the accumulator sum wraps modulo 2^BITS unless REQ-030 applies.
REQ-020 DRAIN, one cycle: absorb the last weight, write acc to internal score slot n, then either return to ISSUE with n+1 or, after n=9, enter DONE.
REQ-021 DONE, one cycle: copy all 10 slots to layer_2 simultaneously, assert done, and return to IDLE.
REQ-022 Latency: with start sampled in cycle 0, done is high in cycle 10*(N_IN+2)+1.
REQ-023 busy is high in ISSUE, DRAIN and DONE, and low in IDLE.
REQ-024 A start while busy is ignored; a start in the same cycle as done is ignored.
REQ-025 layer_2 holds its previous value throughout an evaluation and never shows partial results.
REQ-026 w_addr is 0 whenever the FSM is not in ISSUE.

Reset
REQ-027 rst=1 forces IDLE, busy=0, done=0, w_addr=0, layer_2=0, all score slots and the accumulator to 0, and n=0, independent of clk.
REQ-028 rst asserted mid-evaluation aborts the evaluation; the first start after rst deassertion starts a fresh evaluation.

Configuration
REQ-029 Macro LAYER_2_ENGINE_SAT_EN selects accumulator overflow behaviour.
REQ-030 Defined: every accumulate and every product truncation saturates to 2^(BITS-1)-1 or -2^(BITS-1). Undefined: two's-complement wrap per REQ-018 and REQ-019.

Verification (BITS=32, N_IN=4, FRAC=8)
REQ-031 Reset: assert rst -> layer_2=0, busy=0, done=0, w_addr=0.
REQ-032 All activations 256, all weights 256, all biases 0, pulse start -> done exactly in cycle 61; every score is 32'h00000400.
REQ-033 Activations -256, weights 256, neuron 3 bias 32'h00000100 -> score 3 is 32'hFFFFFD00; all other scores are 32'hFFFFFC00.
REQ-034 Pulse start again in cycle 20 and in cycle 61 -> ignored; only one done occurs and layer_2 is unchanged until cycle 61.
REQ-035 Activations 32'h7FFFFFFF, weights 32'h7FFFFFFF -> with LAYER_2_ENGINE_SAT_EN every score is 32'h7FFFFFFF; without it scores are the wrapped values.
REQ-036 Assert rst in cycle 30 of an evaluation -> busy=0 and layer_2=0 immediately; a new start completes normally 61 cycles later.
